sha256_round_ctrl: RTL and testbench

Sequencer for one SHA-256 compression of a single 512-bit message block in the hash core. It accepts a start request, issues the message-schedule load, steps the round datapath through NUM_ROUNDS rounds, and drives the shared `Block` control into the eight H-register slices (H0..H7). It then holds the finished digest until the consumer acknowledges it. It sits between the miner top level, which supplies header and nonce, and the round/H-register datapath.

---
 rtl/sha256_round_ctrl.sv | 103 ++++++++++
 tb/tb_sha256_round_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl: sequences one single-block SHA-256 compression.
// IDLE -> LOAD (message capture, IV load) -> ROUND x NUM_ROUNDS -> ADD
// (H slices accumulate) -> VALID (digest held until acknowledged).
// All outputs are registered and decoded from the next state, so each
// output is glitch-free and lines up with the state it describes.
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS  = 64,
    parameter int SCHED_WORDS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       digest_ack,
    output logic       busy,
    output logic       load_msg,
    output logic       round_en,
    output logic [5:0] round,
    output logic       sched_expand,
    output logic       block,
    output logic       digest_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_ADD,
        S_VALID
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);
    localparam logic [5:0] FIRST_EXP  = 6'(SCHED_WORDS);

    state_t     state_q, state_d;
    logic [5:0] round_q, round_d;
    logic       busy_q, busy_d;
    logic       load_msg_q, load_msg_d;
    logic       round_en_q, round_en_d;
    logic       sched_expand_q, sched_expand_d;
    logic       block_q, block_d;
    logic       digest_valid_q, digest_valid_d;

    // Next-state logic and next-cycle output decode; abort overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_ROUND;
            S_ROUND: if (round_q == LAST_ROUND) state_d = S_ADD;
            S_ADD:   state_d = S_VALID;
            S_VALID: if (digest_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;

        // Counter restarts at 0 on every ROUND entry and is 0 everywhere else,
        // so it cannot wrap and never leaks a stale index to the K[] lookup.
        round_d = '0;
        if (state_d == S_ROUND && state_q == S_ROUND) round_d = round_q + 6'd1;

        busy_d         = (state_d != S_IDLE);
        load_msg_d     = (state_d == S_LOAD);
        round_en_d     = (state_d == S_ROUND);
        sched_expand_d = (state_d == S_ROUND) && (round_d >= FIRST_EXP);
        // Block stays high across ADD and VALID: the slices add once per high
        // period, and dropping it early would reload IV over the digest.
        block_d        = (state_d == S_ADD) || (state_d == S_VALID);
        digest_valid_d = (state_d == S_VALID);
    end

    // State, round counter and all outputs registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            round_q        <= '0;
            busy_q         <= 1'b0;
            load_msg_q     <= 1'b0;
            round_en_q     <= 1'b0;
            sched_expand_q <= 1'b0;
            block_q        <= 1'b0;
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            round_q        <= round_d;
            busy_q         <= busy_d;
            load_msg_q     <= load_msg_d;
            round_en_q     <= round_en_d;
            sched_expand_q <= sched_expand_d;
            block_q        <= block_d;
            digest_valid_q <= digest_valid_d;
        end
    end

    assign busy         = busy_q;
    assign load_msg     = load_msg_q;
    assign round_en     = round_en_q;
    assign round        = round_q;
    assign sched_expand = sched_expand_q;
    assign block        = block_q;
    assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: each scenario queues per-cycle stimulus with
// the output vector expected after that clock edge, then replays the queue.
module tb_sha256_round_ctrl;

    localparam int NR = 64;
    localparam int SW = 16;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, digest_ack;
    logic       busy, load_msg, round_en, sched_expand, block, digest_valid;
    logic [5:0] round;
    logic [11:0] obs;

    int checks = 0;
    int errors = 0;

    sha256_round_ctrl #(.NUM_ROUNDS(NR), .SCHED_WORDS(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .digest_ack(digest_ack), .busy(busy), .load_msg(load_msg),
        .round_en(round_en), .round(round), .sched_expand(sched_expand),
        .block(block), .digest_valid(digest_valid)
    );

    always #5 clk = ~clk;

    assign obs = {busy, load_msg, round_en, round, sched_expand, block, digest_valid};

    typedef struct {
        logic        st;
        logic        ab;
        logic        ak;
        logic [11:0] exp;
    } ent_t;
    ent_t sb[$];

    localparam logic [11:0] E_IDLE  = 12'h000;
    localparam logic [11:0] E_LOAD  = {1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0};
    localparam logic [11:0] E_ADD   = {1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
    localparam logic [11:0] E_VALID = {1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1};

    function automatic logic [11:0] e_round(input int r);
        return {1'b1, 1'b0, 1'b1, 6'(r), (r >= SW), 1'b0, 1'b0};
    endfunction

    task automatic push(input logic st, input logic ab, input logic ak, input logic [11:0] e);
        ent_t x;
        x.st = st; x.ab = ab; x.ak = ak; x.exp = e;
        sb.push_back(x);
    endtask

    // One full compression: start edge, NR rounds, ADD, nv VALID cycles, then
    // the ack edge back to IDLE. st/ak are also driven on cycles where the
    // controller must ignore them.
    task automatic push_run(input int nv, input logic st, input logic ak);
        push(1'b1, 1'b0, ak, E_LOAD);
        for (int r = 0; r < NR; r++) push(st, 1'b0, ak, e_round(r));
        push(st, 1'b0, ak, E_ADD);
        push(st, 1'b0, ak, E_VALID);
        for (int k = 1; k < nv; k++) push(st, 1'b0, 1'b0, E_VALID);
        push(st, 1'b0, 1'b1, E_IDLE);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; digest_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL reset_state got=%03h exp=%03h", obs, E_IDLE);
        end
        start = 1'b0; digest_ack = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        ent_t e;
        int   n = 0;
        int   ren = 0;
        push_run(22, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            start = e.st; abort = e.ab; digest_ack = e.ak;
            @(posedge clk); #1; n++;
            if (round_en === 1'b1) ren++;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL single cyc=%0d got=%03h exp=%03h", n, obs, e.exp);
            end
        end
        checks++;
        if (ren !== NR) begin
            errors++;
            $display("FAIL round_en_count got=%0d exp=%0d", ren, NR);
        end
    endtask

    task automatic test_ack_cycle70();
        ent_t e;
        int   n = 0;
        push_run(4, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, E_IDLE);
        push_run(4, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            start = e.st; abort = e.ab; digest_ack = e.ak;
            @(posedge clk); #1; n++;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL ack70 cyc=%0d got=%03h exp=%03h", n, obs, e.exp);
            end
        end
    endtask

    task automatic test_abort();
        ent_t e;
        int   n = 0;
        push(1'b1, 1'b0, 1'b0, E_LOAD);
        for (int r = 0; r <= 30; r++) push(1'b0, 1'b0, 1'b0, e_round(r));
        push(1'b1, 1'b1, 1'b1, E_IDLE);   // abort beats start and ack
        push(1'b1, 1'b1, 1'b0, E_IDLE);   // abort beats start in IDLE
        for (int k = 0; k < 3; k++) push(1'b0, 1'b0, 1'b0, E_IDLE);
        push_run(2, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            start = e.st; abort = e.ab; digest_ack = e.ak;
            @(posedge clk); #1; n++;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL abort cyc=%0d got=%03h exp=%03h", n, obs, e.exp);
            end
        end
    endtask

    task automatic test_start_ignored();
        ent_t e;
        int   n = 0;
        push_run(3, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b0, E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            start = e.st; abort = e.ab; digest_ack = e.ak;
            @(posedge clk); #1; n++;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL start_ignored cyc=%0d got=%03h exp=%03h", n, obs, e.exp);
            end
        end
    endtask

    task automatic test_reset_in_add();
        ent_t e;
        int   n = 0;
        int   dv_seen = 0;
        push(1'b1, 1'b0, 1'b0, E_LOAD);
        for (int r = 0; r < NR; r++) push(1'b0, 1'b0, 1'b0, e_round(r));
        push(1'b0, 1'b0, 1'b0, E_ADD);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            start = e.st; abort = e.ab; digest_ack = e.ak;
            @(posedge clk); #1; n++;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL reset_add_pre cyc=%0d got=%03h exp=%03h", n, obs, e.exp);
            end
        end
        // Mid-cycle in ADD: reset must clear outputs without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== E_IDLE) begin
            errors++;
            $display("FAIL reset_async got=%03h exp=%03h", obs, E_IDLE);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (digest_valid === 1'b1) dv_seen++;
            checks++;
            if (obs !== E_IDLE) begin
                errors++;
                $display("FAIL reset_hold k=%0d got=%03h exp=%03h", k, obs, E_IDLE);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) push(1'b0, 1'b0, 1'b0, E_IDLE);
        push_run(2, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            start = e.st; abort = e.ab; digest_ack = e.ak;
            @(posedge clk); #1; n++;
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL reset_add_post cyc=%0d got=%03h exp=%03h", n, obs, e.exp);
            end
        end
        checks++;
        if (dv_seen !== 0) begin
            errors++;
            $display("FAIL reset_no_digest got=%0d exp=0", dv_seen);
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        int   n = 0;
        int   last_dv = -1;
        int   gap_bad = 0;
        for (int c = 0; c < 3; c++) push_run(1, 1'b1, 1'b1);
        push(1'b0, 1'b0, 1'b0, E_IDLE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            start = e.st; abort = e.ab; digest_ack = e.ak;
            @(posedge clk); #1; n++;
            if (digest_valid === 1'b1) begin
                if (last_dv >= 0 && (n - last_dv) != NR + 4) gap_bad++;
                last_dv = n;
            end
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%03h exp=%03h", n, obs, e.exp);
            end
        end
        checks++;
        if (gap_bad !== 0 || last_dv < 0) begin
            errors++;
            $display("FAIL b2b_period bad_gaps=%0d last=%0d exp_gap=%0d", gap_bad, last_dv, NR + 4);
        end
        start = 1'b0; digest_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_ack_cycle70();
        test_abort();
        test_start_ignored();
        test_reset_in_add();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
